alu_arbiter: RTL and testbench

//  Shares the single milano ALU between NUM_REQ requesters (e.g. ex stage, branch/AGU helper).
//  - Picks one valid request per cycle and drives it onto the ALU inputs.
//  - Captures the ALU result in a one-entry response register tagged with the requester id.
//  - Full throughput (1 op/cycle) while the consumer keeps rsp_ready_i high.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares the single milano ALU between NUM_REQ requesters and registers the ALU result
// in a one-entry response slot tagged with the requester index.

package milano_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opt_e;

endpackage

module alu_arbiter
  import milano_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter bit  RR_EN   = 1'b1,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic     [NUM_REQ-1:0]        req_valid_i,
  output logic     [NUM_REQ-1:0]        req_ready_o,
  input  alu_opt_e [NUM_REQ-1:0]        req_op_i,
  input  logic     [NUM_REQ-1:0][31:0]  req_a_i,
  input  logic     [NUM_REQ-1:0][31:0]  req_b_i,
  input  logic     [NUM_REQ-1:0][4:0]   req_rd_addr_i,
  input  logic     [NUM_REQ-1:0]        req_rd_we_i,

  output alu_opt_e                      alu_operator_o,
  output logic     [31:0]               alu_operand_a_o,
  output logic     [31:0]               alu_operand_b_o,
  output logic     [4:0]                alu_rd_addr_o,
  output logic                          alu_rd_wr_en_o,
  input  logic                          alu_reg_we_i,
  input  logic     [4:0]                alu_wr_addr_i,
  input  logic     [31:0]               alu_rd_wdata_i,

  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic     [IDW-1:0]            rsp_id_o,
  output logic                          rsp_we_o,
  output logic     [4:0]                rsp_addr_o,
  output logic     [31:0]               rsp_data_o
);

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     start_idx;
  logic               can_accept;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_we_q, rsp_we_d;
  logic [4:0]         rsp_addr_q, rsp_addr_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  // The response slot can be refilled in the same cycle it is drained.
  assign can_accept = !rsp_valid_q || rsp_ready_i;
  assign start_idx  = RR_EN ? ptr_q : '0;

  // Circular search from start_idx; the first valid requester found wins.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(start_idx) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (can_accept && !gnt_any && req_valid_i[IDW'(idx)]) begin
        gnt[IDW'(idx)] = 1'b1;
        gnt_any        = 1'b1;
        gnt_id         = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR_EN && gnt_any) begin
      ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Idle drive is a harmless ADD 0+0 with the write enable low.
  always_comb begin
    alu_operator_o  = ALU_ADD;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    alu_rd_addr_o   = '0;
    alu_rd_wr_en_o  = 1'b0;
    if (gnt_any) begin
      alu_operator_o  = req_op_i[gnt_id];
      alu_operand_a_o = req_a_i[gnt_id];
      alu_operand_b_o = req_b_i[gnt_id];
      alu_rd_addr_o   = req_rd_addr_i[gnt_id];
      alu_rd_wr_en_o  = req_rd_we_i[gnt_id];
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_we_d    = rsp_we_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    if (gnt_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_we_d    = alu_reg_we_i;
      rsp_addr_d  = alu_wr_addr_i;
      rsp_data_d  = alu_rd_wdata_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_we_q    <= rsp_we_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: two-requester round-robin and fixed-priority
// instances plus a four-requester round-robin instance, each behind a small ALU model.

module tb_alu_arbiter;
  import milano_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t q_4[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(alu_opt_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  // Shared two-requester payload; rr and fp instances have separate valids.
  logic [1:0]             v_rr, v_fp;
  alu_opt_e [1:0]         op2;
  logic [1:0][31:0]       a2, b2;
  logic [1:0][4:0]        rd2;
  logic [1:0]             we2;
  logic                   rsp_ready;

  logic [1:0]  rr_gnt, fp_gnt;
  alu_opt_e    rr_op, fp_op;
  logic [31:0] rr_a, rr_b, fp_a, fp_b;
  logic [4:0]  rr_rd, fp_rd;
  logic        rr_we, fp_we;
  logic        rr_rsp_valid, fp_rsp_valid;
  logic [0:0]  rr_rsp_id, fp_rsp_id;
  logic        rr_rsp_we, fp_rsp_we;
  logic [4:0]  rr_rsp_addr, fp_rsp_addr;
  logic [31:0] rr_rsp_data, fp_rsp_data;

  logic [3:0]        v4;
  alu_opt_e [3:0]    op4;
  logic [3:0][31:0]  a4, b4;
  logic [3:0][4:0]   rd4;
  logic [3:0]        we4;
  logic              rsp_ready4;
  logic [3:0]        g4;
  alu_opt_e          q4_op;
  logic [31:0]       q4_a, q4_b;
  logic [4:0]        q4_rd;
  logic              q4_we;
  logic              r4_valid, r4_we;
  logic [1:0]        r4_id;
  logic [4:0]        r4_addr;
  logic [31:0]       r4_data;

  alu_arbiter #(.NUM_REQ(2), .RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v_rr), .req_ready_o(rr_gnt), .req_op_i(op2), .req_a_i(a2), .req_b_i(b2),
    .req_rd_addr_i(rd2), .req_rd_we_i(we2),
    .alu_operator_o(rr_op), .alu_operand_a_o(rr_a), .alu_operand_b_o(rr_b),
    .alu_rd_addr_o(rr_rd), .alu_rd_wr_en_o(rr_we),
    .alu_reg_we_i(rr_we), .alu_wr_addr_i(rr_rd), .alu_rd_wdata_i(alu_f(rr_op, rr_a, rr_b)),
    .rsp_valid_o(rr_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rr_rsp_id),
    .rsp_we_o(rr_rsp_we), .rsp_addr_o(rr_rsp_addr), .rsp_data_o(rr_rsp_data)
  );

  alu_arbiter #(.NUM_REQ(2), .RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v_fp), .req_ready_o(fp_gnt), .req_op_i(op2), .req_a_i(a2), .req_b_i(b2),
    .req_rd_addr_i(rd2), .req_rd_we_i(we2),
    .alu_operator_o(fp_op), .alu_operand_a_o(fp_a), .alu_operand_b_o(fp_b),
    .alu_rd_addr_o(fp_rd), .alu_rd_wr_en_o(fp_we),
    .alu_reg_we_i(fp_we), .alu_wr_addr_i(fp_rd), .alu_rd_wdata_i(alu_f(fp_op, fp_a, fp_b)),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(fp_rsp_id),
    .rsp_we_o(fp_rsp_we), .rsp_addr_o(fp_rsp_addr), .rsp_data_o(fp_rsp_data)
  );

  alu_arbiter #(.NUM_REQ(4), .RR_EN(1'b1)) u_4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v4), .req_ready_o(g4), .req_op_i(op4), .req_a_i(a4), .req_b_i(b4),
    .req_rd_addr_i(rd4), .req_rd_we_i(we4),
    .alu_operator_o(q4_op), .alu_operand_a_o(q4_a), .alu_operand_b_o(q4_b),
    .alu_rd_addr_o(q4_rd), .alu_rd_wr_en_o(q4_we),
    .alu_reg_we_i(q4_we), .alu_wr_addr_i(q4_rd), .alu_rd_wdata_i(alu_f(q4_op, q4_a, q4_b)),
    .rsp_valid_o(r4_valid), .rsp_ready_i(rsp_ready4), .rsp_id_o(r4_id),
    .rsp_we_o(r4_we), .rsp_addr_o(r4_addr), .rsp_data_o(r4_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_rsp(input string tag, input exp_t e, input logic [2:0] id,
                         input logic we, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_id"}, 32'(id), 32'(e.id));
    check({tag, "_we"}, 32'(we), 32'(e.we));
    check({tag, "_addr"}, 32'(addr), 32'(e.addr));
    check({tag, "_data"}, data, e.data);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected: response with empty scoreboard at %0t", tag, $time);
  endtask

  // Monitors: a response is consumed at the edge after a cycle with valid & ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rr_rsp_valid && rsp_ready) begin
      if (q_rr.size() == 0) unexpected("rr");
      else begin
        e = q_rr.pop_front();
        cmp_rsp("rr", e, 3'(rr_rsp_id), rr_rsp_we, rr_rsp_addr, rr_rsp_data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fp_rsp_valid && rsp_ready) begin
      if (q_fp.size() == 0) unexpected("fp");
      else begin
        e = q_fp.pop_front();
        cmp_rsp("fp", e, 3'(fp_rsp_id), fp_rsp_we, fp_rsp_addr, fp_rsp_data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && r4_valid && rsp_ready4) begin
      if (q_4.size() == 0) unexpected("n4");
      else begin
        e = q_4.pop_front();
        cmp_rsp("n4", e, 3'(r4_id), r4_we, r4_addr, r4_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input alu_opt_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic we);
    op2[i] = op; a2[i] = a; b2[i] = b; rd2[i] = rd; we2[i] = we;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    v_rr = '0; v_fp = '0; rsp_ready = 1'b0;
    set_req(0, ALU_ADD, 0, 0, 0, 1'b0);
    set_req(1, ALU_ADD, 0, 0, 0, 1'b0);
    v4 = '0; rsp_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op4[i] = ALU_ADD; a4[i] = 32'(i * 10); b4[i] = 32'd1; rd4[i] = 5'(i + 8); we4[i] = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    check("rst_rsp_valid", 32'(rr_rsp_valid), 0);
    check("rst_rsp_data", rr_rsp_data, 0);
    check("rst_rsp_id", 32'(rr_rsp_id), 0);
    check("rst_gnt", 32'(rr_gnt), 0);
    check("rst_alu_op", 32'(rr_op), 32'(ALU_ADD));

    // Single request on req1: ADD 5+7 -> rd3
    cyc();
    set_req(1, ALU_ADD, 5, 7, 3, 1'b1);
    v_rr = 2'b10; rsp_ready = 1'b1;
    smp();
    check("single_gnt", 32'(rr_gnt), 32'b10);
    check("single_alu_a", rr_a, 5);
    check("single_alu_rd", 32'(rr_rd), 3);
    q_rr.push_back('{id: 3'd1, we: 1'b1, addr: 5'd3, data: 32'd12});
    cyc();
    v_rr = 2'b00;
    smp();
    check("single_rsp_valid", 32'(rr_rsp_valid), 1);
    check("idle_gnt", 32'(rr_gnt), 0);
    check("idle_alu_we", 32'(rr_we), 0);
    check("idle_alu_op", 32'(rr_op), 32'(ALU_ADD));
    check("idle_alu_a", rr_a, 0);
    cyc();
    smp();
    check("idle_drained", 32'(rr_rsp_valid), 0);

    // Contention: rr alternates 0,1,0,1; fixed priority always picks 0
    cyc();
    set_req(0, ALU_ADD, 1, 2, 1, 1'b1);
    set_req(1, ALU_SUB, 20, 5, 2, 1'b0);
    v_rr = 2'b11; v_fp = 2'b11;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (k % 2 == 0) begin
        check("rr_gnt_even", 32'(rr_gnt), 32'b01);
        q_rr.push_back('{id: 3'd0, we: 1'b1, addr: 5'd1, data: 32'd3});
      end else begin
        check("rr_gnt_odd", 32'(rr_gnt), 32'b10);
        q_rr.push_back('{id: 3'd1, we: 1'b0, addr: 5'd2, data: 32'd15});
      end
      check("fp_gnt", 32'(fp_gnt), 32'b01);
      q_fp.push_back('{id: 3'd0, we: 1'b1, addr: 5'd1, data: 32'd3});
      cyc();
    end
    v_rr = 2'b00; v_fp = 2'b00;
    smp();

    // Backpressure: SUB 10-3 held for three stalled cycles
    cyc();
    set_req(0, ALU_SUB, 10, 3, 4, 1'b1);
    v_rr = 2'b01; rsp_ready = 1'b1;
    smp();
    check("bp_gnt", 32'(rr_gnt), 32'b01);
    q_rr.push_back('{id: 3'd0, we: 1'b1, addr: 5'd4, data: 32'd7});
    cyc();
    set_req(0, ALU_ADD, 100, 1, 5, 1'b1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("bp_stall_gnt", 32'(rr_gnt), 0);
      check("bp_stall_valid", 32'(rr_rsp_valid), 1);
      check("bp_stall_data", rr_rsp_data, 7);
      check("bp_stall_addr", 32'(rr_rsp_addr), 4);
      cyc();
    end
    rsp_ready = 1'b1;
    smp();
    check("bp_refill_gnt", 32'(rr_gnt), 32'b01);
    q_rr.push_back('{id: 3'd0, we: 1'b1, addr: 5'd5, data: 32'd101});
    cyc();
    v_rr = 2'b00;
    smp();
    cyc();
    smp();
    check("bp_drained", 32'(rr_rsp_valid), 0);

    // Wrap on four requesters: req2 moves ptr to 3, then {0,2} -> 0, then 2, then {0,3} -> 3
    cyc();
    v4 = 4'b0100;
    smp();
    check("wrap_gnt_a", 32'(g4), 32'b0100);
    q_4.push_back('{id: 3'd2, we: 1'b1, addr: 5'd10, data: 32'd21});
    cyc();
    v4 = 4'b0101;
    smp();
    check("wrap_gnt_b", 32'(g4), 32'b0001);
    q_4.push_back('{id: 3'd0, we: 1'b1, addr: 5'd8, data: 32'd1});
    cyc();
    v4 = 4'b0100;
    smp();
    check("wrap_gnt_c", 32'(g4), 32'b0100);
    q_4.push_back('{id: 3'd2, we: 1'b1, addr: 5'd10, data: 32'd21});
    cyc();
    v4 = 4'b1001;
    smp();
    check("wrap_gnt_d", 32'(g4), 32'b1000);
    q_4.push_back('{id: 3'd3, we: 1'b1, addr: 5'd11, data: 32'd31});
    cyc();
    v4 = 4'b0000;
    smp();

    // Reset mid-stall: held response discarded, ptr returns to 0
    cyc();
    set_req(0, ALU_ADD, 1, 2, 1, 1'b1);
    v_rr = 2'b01; rsp_ready = 1'b0;
    smp();
    check("rst_pre_gnt", 32'(rr_gnt), 32'b01);
    cyc();
    smp();
    check("rst_pre_stall", 32'(rr_rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(rr_rsp_valid), 0);
    check("rst_async_data", rr_rsp_data, 0);
    cyc();
    rst_n = 1'b1;
    v_rr = 2'b11; rsp_ready = 1'b1;
    smp();
    check("rst_first_gnt", 32'(rr_gnt), 32'b01);
    q_rr.push_back('{id: 3'd0, we: 1'b1, addr: 5'd1, data: 32'd3});
    cyc();
    v_rr = 2'b00;
    smp();
    cyc();
    smp();

    check("rr_queue_empty", 32'(q_rr.size()), 0);
    check("fp_queue_empty", 32'(q_fp.size()), 0);
    check("n4_queue_empty", 32'(q_4.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
